// File: rtl/s_array_pkg.sv
// Shared definitions for the S-array memory and its clients (FSM encodings,
// default geometry, seed word).
package s_array_pkg;

  localparam int          T_DEF = 16;
  localparam int          W_DEF = 32;
  localparam logic [31:0] P_DEF = 32'hB7E15163;

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_READY = 3'b001
  } state_t;

endpackage

// File: rtl/s_array_ram.sv
// Plain T x W single-port synchronous RAM, read-first, no reset on contents.
module s_array_ram #(
  parameter  int T  = 16,
  parameter  int W  = 32,
  localparam int AW = $clog2(T)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [T];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/s_array_mem.sv
// S-array memory: self-initialising T x W array (P at address 0, zeros
// elsewhere) with one-cycle registered client access and a sticky range error.
// Optional S_MEM_BYPASS_EN: same-cycle write/read returns the new data.
module s_array_mem
  import s_array_pkg::*;
#(
  parameter  int          T        = T_DEF,
  parameter  int          W        = W_DEF,
  parameter  logic [W-1:0] P       = W'(P_DEF),
  localparam int          T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iInit,
  input  logic [T_LENGTH-1:0] iS_address,
  input  logic                iS_we,
  input  logic [W-1:0]        iS_sub_i_prima,
  output logic [W-1:0]        oS_sub_i,
  output logic                oReady,
  output logic                oErr,
  output logic [2:0]          fsm_state
);

  // Handshake: no valid/ready pair on the client side; oReady=1 means every
  // cycle is an accepted access (read always, write when iS_we=1).

  state_t              state, state_nx;
  logic [T_LENGTH-1:0] cnt, cnt_nx;
  logic                valid_q, err_q;

  logic                in_range;
  logic                client_ok;
  logic                ram_we;
  logic [T_LENGTH-1:0] ram_addr;
  logic [W-1:0]        ram_wdata, ram_rdata;

  assign in_range  = {1'b0, iS_address} < (T_LENGTH+1)'(T);
  assign client_ok = (state == ST_READY) && !iInit && in_range;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = iS_sub_i_prima;
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = (cnt == '0) ? P : '0;
        if (iInit) begin
          cnt_nx = '0;
        end else if (cnt == T_LENGTH'(T - 1)) begin
          cnt_nx   = '0;
          state_nx = ST_READY;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_READY: begin
        // Out-of-range addresses are steered to 0 with the write blocked.
        ram_we   = client_ok && iS_we;
        ram_addr = in_range ? iS_address : '0;
        if (iInit) begin
          state_nx = ST_INIT;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      valid_q <= client_ok;
      if (iInit)
        err_q <= 1'b0;
      else if ((state == ST_READY) && !in_range)
        err_q <= 1'b1;
    end
  end

  s_array_ram #(.T(T), .W(W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef S_MEM_BYPASS_EN
  logic         byp_q;
  logic [W-1:0] byp_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= client_ok && iS_we;
      byp_data_q <= iS_sub_i_prima;
    end
  end

  assign oS_sub_i = !valid_q ? '0 : (byp_q ? byp_data_q : ram_rdata);
`else
  assign oS_sub_i = valid_q ? ram_rdata : '0;
`endif

  assign oReady    = (state == ST_READY);
  assign oErr      = err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_s_array_mem.sv
// Directed bench for s_array_mem: a T=16 instance for the main function and a
// T=12 instance for the out-of-range error path.
module tb_s_array_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        init_a = 1'b0;
  logic [3:0]  addr_a = '0;
  logic        we_a   = 1'b0;
  logic [31:0] wd_a   = '0;
  logic [31:0] rd_a;
  logic        ready_a, err_a;
  logic [2:0]  st_a;

  logic        init_b = 1'b0;
  logic [3:0]  addr_b = '0;
  logic        we_b   = 1'b0;
  logic [31:0] wd_b   = '0;
  logic [31:0] rd_b;
  logic        ready_b, err_b;
  logic [2:0]  st_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] P = 32'hB7E15163;

  always #5 clk = ~clk;

  s_array_mem #(.T(16), .W(32), .P(P)) dut_a (
    .clk(clk), .rst(rst), .iInit(init_a), .iS_address(addr_a), .iS_we(we_a),
    .iS_sub_i_prima(wd_a), .oS_sub_i(rd_a), .oReady(ready_a), .oErr(err_a),
    .fsm_state(st_a)
  );

  s_array_mem #(.T(12), .W(32), .P(P)) dut_b (
    .clk(clk), .rst(rst), .iInit(init_b), .iS_address(addr_b), .iS_we(we_b),
    .iS_sub_i_prima(wd_b), .oS_sub_i(rd_b), .oReady(ready_b), .oErr(err_b),
    .fsm_state(st_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until dut_a reports ready; returns the cycle count or -1 on timeout.
  task automatic wait_ready_a(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_a) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  logic [31:0] exp_byp;

  initial begin
    // Reset state
    #12;
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_data", rd_a, 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_state", 32'(st_a), 32'd0);

    // Release reset just after an edge; oReady after 16 edges
    tick();
    rst = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 8) begin
        check("init_data_zero", rd_a, 32'd0);
        check("init_state", 32'(st_a), 32'd0);
      end
      if (ready_a) begin
        n = i;
        break;
      end
    end
    check("ready_latency", 32'(n), 32'd16);
    check("ready_state", 32'(st_a), 32'd1);

    // Read back the initialised array
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      tick();
      check($sformatf("init_word_%0d", i), rd_a, (i == 0) ? P : 32'd0);
    end

    // Write then read address 1
    addr_a = 4'd1; we_a = 1'b1; wd_a = 32'h5618CB1C;
    tick();
    we_a = 1'b0;
    tick();
    check("write_readback_a1", rd_a, 32'h5618CB1C);

    // Same-cycle write/read of address 3
`ifdef S_MEM_BYPASS_EN
    exp_byp = 32'hAAAA5555;
`else
    exp_byp = 32'd0;
`endif
    addr_a = 4'd3; we_a = 1'b1; wd_a = 32'hAAAA5555;
    tick();
    check("same_cycle_a3", rd_a, exp_byp);
    we_a = 1'b0;
    tick();
    check("after_write_a3", rd_a, 32'hAAAA5555);

    // iInit together with a write to address 2: write dropped, full re-init
    addr_a = 4'd2; we_a = 1'b1; wd_a = 32'hDEADBEEF; init_a = 1'b1;
    tick();
    init_a = 1'b0; we_a = 1'b0;
    check("iinit_ready_low", 32'(ready_a), 32'd0);
    check("iinit_data_zero", rd_a, 32'd0);
    wait_ready_a(n);
    check("reinit_latency", 32'(n), 32'd16);
    addr_a = 4'd2;
    tick();
    check("reinit_a2", rd_a, 32'd0);
    addr_a = 4'd1;
    tick();
    check("reinit_a1", rd_a, 32'd0);
    addr_a = 4'd0;
    tick();
    check("reinit_a0", rd_a, P);
    check("no_err_a", 32'(err_a), 32'd0);

    // Reset at cycle 8 of INIT
    init_a = 1'b1;
    tick();
    init_a = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    check("midinit_rst_ready", 32'(ready_a), 32'd0);
    tick();
    rst = 1'b1;
    wait_ready_a(n);
    check("midinit_rst_latency", 32'(n), 32'd16);

    // T=12 instance: already initialised by now (12 < 16 cycles)
    check("b_ready", 32'(ready_b), 32'd1);
    addr_b = 4'd13; we_b = 1'b1; wd_b = 32'hFFFF0000;
    tick();
    we_b = 1'b0;
    check("b_oob_data", rd_b, 32'd0);
    check("b_oob_err", 32'(err_b), 32'd1);
    addr_b = 4'd0;
    tick();
    check("b_a0_untouched", rd_b, P);
    check("b_err_sticky", 32'(err_b), 32'd1);
    addr_b = 4'd11;
    tick();
    check("b_a11", rd_b, 32'd0);
    init_b = 1'b1;
    tick();
    init_b = 1'b0;
    check("b_err_cleared", 32'(err_b), 32'd0);
    check("b_reinit_ready", 32'(ready_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s_array_mem.md
S_ARRAY_MEM -- requirements
Module: s_array_mem

Interface
REQ-001 SHALL have parameter T, default 16: number of S-array words.
REQ-002 SHALL have parameter W, default 32: word width in bits.
REQ-003 SHALL have parameter P, default 32'hB7E15163: seed word loaded at address 0.
REQ-004 SHALL have derived constant T_LENGTH = $clog2(T): address width.
REQ-005 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port iInit  input  1: synchronous re-initialisation request.
REQ-008 SHALL have port iS_address  input  T_LENGTH: client word address.
REQ-009 SHALL have port iS_we  input  1: client write enable.
REQ-010 SHALL have port iS_sub_i_prima  input  W: client write data.
REQ-011 SHALL have port oS_sub_i  output  W: registered read data.
REQ-012 SHALL have port oReady  output  1: array initialised; client access accepted.
REQ-013 SHALL have port oErr  output  1: sticky flag, access to address >= T.

Function
REQ-014 SHALL implement FSM states INIT (3'b000), READY (3'b001).
REQ-015 INIT SHALL walk internal counter 0..T-1, one word per cycle: P to address 0, zero to all others; last write then goes to READY.
REQ-016 oReady SHALL be 0 in INIT and 1 in READY; oReady rises T cycles after reset release.
REQ-017 In INIT, client iS_we SHALL be ignored and oS_sub_i SHALL hold 0.
REQ-018 In READY, oS_sub_i SHALL equal mem[iS_address] sampled at the previous edge (read latency 1 cycle).
REQ-019 In READY with iS_we=1 and iS_address < T, mem[iS_address] SHALL take iS_sub_i_prima at the edge.
REQ-020 Read and write of the same address in the same cycle SHALL return the old data (read-first), unless REQ-027 applies.
REQ-021 Any READY access with iS_address >= T SHALL perform no write, return 0, and set oErr until reset or iInit.
REQ-022 iInit=1 in READY SHALL return to INIT with counter 0, clear oErr, and drop oReady next cycle; iInit in INIT restarts the counter.
REQ-023 iInit and iS_we in the same cycle: iInit SHALL win; the write is dropped.

Reset
REQ-024 Asserting rst SHALL, asynchronously: state=INIT, counter=0, oS_sub_i=0, oReady=0, oErr=0.
REQ-025 Array contents SHALL NOT be reset asynchronously; they are defined only after INIT completes.
REQ-026 Reset mid-INIT or mid-READY SHALL restart the full T-cycle initialisation.

Configuration
REQ-027 With S_MEM_BYPASS_EN defined, a same-cycle write and read to one address SHALL return the new write data (write-first). Without it, behaviour SHALL be read-first per REQ-020.

Structure
REQ-028 State encodings, default P, and default T/W SHALL live in shared package s_array_pkg, which is also used by S_operation.
REQ-029 Storage SHALL be a sub-module s_array_ram: a plain T x W single-port synchronous RAM with no reset. The FSM and address mux SHALL stay in s_array_mem.

Verification (T=16, W=32, P=32'hB7E15163)
REQ-030 Release reset, then read addresses 0..15 after oReady: oReady rises at cycle 16; data 32'hB7E15163 at address 0, 0 elsewhere.
REQ-031 Write 32'h5618CB1C to address 1, read address 1 the next cycle: oS_sub_i=32'h5618CB1C one cycle after the read address.
REQ-032 Same-cycle write 32'hAAAA5555 and read of address 3 (old value 0): returns 0; returns 32'hAAAA5555 with S_MEM_BYPASS_EN.
REQ-033 Assert iInit together with a write to address 2 in READY: write dropped; oReady=0 for 16 cycles; address 2 reads 0 afterwards.
REQ-034 Assert rst at cycle 8 of INIT, then release: oReady rises exactly 16 cycles after release.
REQ-035 Build with T=12 and access address 13: no write, oS_sub_i=0, oErr=1 until iInit.
